// File: rtl/seq_gen_serial_if.sv
// seq_gen_serial_if: control/serial bundle between a controller (master) and seq_gen_serial (slave).
//   start, pattern, repeat_cnt, msb_first : controller -> generator
//   x, x_valid, busy, done                : generator -> controller / downstream detector
interface seq_gen_serial_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic             msb_first;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;
  modport master (output start, pattern, repeat_cnt, msb_first, input x, x_valid, busy, done);
  modport slave  (input start, pattern, repeat_cnt, msb_first, output x, x_valid, busy, done);
endinterface

// File: rtl/seq_gen_serial.sv
// seq_gen_serial: serial bit-pattern transmitter, repeats a captured pattern a programmable number of passes.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : seq_gen_serial_if.slave (start/pattern/repeat_cnt/msb_first in; x/x_valid/busy/done out)
//   Optional macro SEQ_GEN_PARITY_EN appends an even-parity bit after each pass.
module seq_gen_serial #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic             clk,
  input logic             rst,
  seq_gen_serial_if.slave bus
);
`ifdef SEQ_GEN_PARITY_EN
  localparam int LEN = WIDTH + 1;
`else
  localparam int LEN = WIDTH;
`endif
  localparam int BW = $clog2(LEN);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d, sh_q, sh_d;
  logic             msb_q, msb_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic             x_q, x_d, xv_q, xv_d, busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] src, load_sh;
  logic             src_msb, load_x, next_x;
  // Loads come from the bus in IDLE and from the captured copy on a pass reload.
  assign src     = state_q == IDLE ? bus.pattern : pat_q;
  assign src_msb = state_q == IDLE ? bus.msb_first : msb_q;
  assign load_x  = src_msb ? src[WIDTH-1] : src[0];
  assign load_sh = src_msb ? src << 1 : src >> 1;
`ifdef SEQ_GEN_PARITY_EN
  assign next_x = bit_q == BW'(WIDTH - 1) ? ^pat_q : (msb_q ? sh_q[WIDTH-1] : sh_q[0]);
`else
  assign next_x = msb_q ? sh_q[WIDTH-1] : sh_q[0];
`endif
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    sh_d    = sh_q;
    msb_d   = msb_q;
    bit_d   = bit_q;
    pass_d  = pass_q;
    x_d     = 1'b0;
    xv_d    = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = SHIFT;
        pat_d   = bus.pattern;
        msb_d   = bus.msb_first;
        pass_d  = bus.repeat_cnt == '0 ? CNT_W'(1) : bus.repeat_cnt;
        sh_d    = load_sh;
        bit_d   = '0;
        x_d     = load_x;
        xv_d    = 1'b1;
        busy_d  = 1'b1;
      end
      SHIFT: if (bit_q == BW'(LEN - 1)) begin
        if (pass_q > CNT_W'(1)) begin
          pass_d = pass_q - 1'b1;
          sh_d   = load_sh;
          bit_d  = '0;
          x_d    = load_x;
          xv_d   = 1'b1;
          busy_d = 1'b1;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end else begin
        bit_d  = bit_q + 1'b1;
        sh_d   = msb_q ? sh_q << 1 : sh_q >> 1;
        x_d    = next_x;
        xv_d   = 1'b1;
        busy_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      sh_q    <= '0;
      msb_q   <= 1'b0;
      bit_q   <= '0;
      pass_q  <= '0;
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      sh_q    <= sh_d;
      msb_q   <= msb_d;
      bit_q   <= bit_d;
      pass_q  <= pass_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign bus.x       = x_q;
  assign bus.x_valid = xv_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_seq_gen_serial.sv
// tb_seq_gen_serial: directed self-checking bench for seq_gen_serial.
module tb_seq_gen_serial;
  logic clk, rst;
  int n_cmp = 0;
  int n_err = 0;
  seq_gen_serial_if #(.WIDTH(8), .CNT_W(4)) bus ();
  seq_gen_serial #(.WIDTH(8), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.pattern = '0; bus.repeat_cnt = '0; bus.msb_first = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.busy, bus.x_valid, bus.x} !== 4'b0000) begin
      n_err++; $display("FAIL reset: got done/busy/x_valid/x=%b want 0000", {bus.done, bus.busy, bus.x_valid, bus.x});
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.busy, bus.x_valid, bus.x} !== 4'b0000) begin
      n_err++; $display("FAIL reset_release: got %b want 0000", {bus.done, bus.busy, bus.x_valid, bus.x});
    end
  endtask

  task automatic test_msb_first();
    logic [7:0] s;
    s = 8'b0111_0111;
    bus.pattern = 8'h77; bus.msb_first = 1'b1; bus.repeat_cnt = 4'd1; bus.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) bus.start = 1'b0;
      n_cmp++;
      if ({bus.done, bus.busy, bus.x_valid, bus.x} !== {3'b011, s[7-i]}) begin
        n_err++; $display("FAIL msb_first bit%0d: got done/busy/v/x=%b want %b", i, {bus.done, bus.busy, bus.x_valid, bus.x}, {3'b011, s[7-i]});
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.busy, bus.x_valid, bus.x} !== 4'b1000) begin
      n_err++; $display("FAIL msb_first done: got %b want 1000", {bus.done, bus.busy, bus.x_valid, bus.x});
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.busy, bus.x_valid, bus.x} !== 4'b0000) begin
      n_err++; $display("FAIL msb_first idle: got %b want 0000", {bus.done, bus.busy, bus.x_valid, bus.x});
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] s;
    s = 8'b1110_1110;
    bus.pattern = 8'h77; bus.msb_first = 1'b0; bus.repeat_cnt = 4'd1; bus.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) bus.start = 1'b0;
      n_cmp++;
      if ({bus.done, bus.busy, bus.x_valid, bus.x} !== {3'b011, s[7-i]}) begin
        n_err++; $display("FAIL lsb_first bit%0d: got %b want %b", i, {bus.done, bus.busy, bus.x_valid, bus.x}, {3'b011, s[7-i]});
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.busy, bus.x_valid, bus.x} !== 4'b1000) begin
      n_err++; $display("FAIL lsb_first done: got %b want 1000", {bus.done, bus.busy, bus.x_valid, bus.x});
    end
    @(negedge clk);
  endtask

  task automatic test_repeat();
    logic [7:0] s;
    s = 8'hA5;
    bus.pattern = 8'hA5; bus.msb_first = 1'b1; bus.repeat_cnt = 4'd3; bus.start = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 0) bus.start = 1'b0;
      n_cmp++;
      if ({bus.done, bus.busy, bus.x_valid, bus.x} !== {3'b011, s[7-(i%8)]}) begin
        n_err++; $display("FAIL repeat bit%0d: got %b want %b", i, {bus.done, bus.busy, bus.x_valid, bus.x}, {3'b011, s[7-(i%8)]});
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.busy, bus.x_valid, bus.x} !== 4'b1000) begin
      n_err++; $display("FAIL repeat done: got %b want 1000", {bus.done, bus.busy, bus.x_valid, bus.x});
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_err++; $display("FAIL repeat done_single: got done=%b want 0", bus.done);
    end
  endtask

  task automatic test_zero_repeat();
    bus.pattern = 8'hFF; bus.msb_first = 1'b1; bus.repeat_cnt = 4'd0; bus.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) bus.start = 1'b0;
      n_cmp++;
      if ({bus.done, bus.busy, bus.x_valid, bus.x} !== 4'b0111) begin
        n_err++; $display("FAIL zero_repeat bit%0d: got %b want 0111", i, {bus.done, bus.busy, bus.x_valid, bus.x});
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.busy, bus.x_valid, bus.x} !== 4'b1000) begin
      n_err++; $display("FAIL zero_repeat done: got %b want 1000", {bus.done, bus.busy, bus.x_valid, bus.x});
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    logic [7:0] s;
    s = 8'hF0;
    bus.pattern = 8'hF0; bus.msb_first = 1'b1; bus.repeat_cnt = 4'd1; bus.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) bus.start = 1'b0;
      n_cmp++;
      if ({bus.done, bus.busy, bus.x_valid, bus.x} !== {3'b011, s[7-i]}) begin
        n_err++; $display("FAIL ignore_start bit%0d: got %b want %b", i, {bus.done, bus.busy, bus.x_valid, bus.x}, {3'b011, s[7-i]});
      end
      if (i == 3) begin
        bus.start = 1'b1; bus.pattern = 8'h00; bus.repeat_cnt = 4'd5; bus.msb_first = 1'b0;
      end
      if (i == 4) bus.start = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.busy, bus.x_valid, bus.x} !== 4'b1000) begin
      n_err++; $display("FAIL ignore_start done: got %b want 1000", {bus.done, bus.busy, bus.x_valid, bus.x});
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.busy, bus.x_valid, bus.x} !== 4'b0000) begin
      n_err++; $display("FAIL ignore_start no_queue: got %b want 0000", {bus.done, bus.busy, bus.x_valid, bus.x});
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] s;
    s = 8'h77;
    bus.pattern = 8'h77; bus.msb_first = 1'b1; bus.repeat_cnt = 4'd2; bus.start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) bus.start = 1'b0;
      n_cmp++;
      if ({bus.done, bus.busy, bus.x_valid, bus.x} !== {3'b011, s[7-i]}) begin
        n_err++; $display("FAIL async_reset pre bit%0d: got %b want %b", i, {bus.done, bus.busy, bus.x_valid, bus.x}, {3'b011, s[7-i]});
      end
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.done, bus.busy, bus.x_valid, bus.x} !== 4'b0000) begin
      n_err++; $display("FAIL async_reset immediate: got %b want 0000", {bus.done, bus.busy, bus.x_valid, bus.x});
    end
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.busy, bus.x_valid, bus.x} !== 4'b0000) begin
      n_err++; $display("FAIL async_reset no_done: got %b want 0000", {bus.done, bus.busy, bus.x_valid, bus.x});
    end
    s = 8'h81;
    bus.pattern = 8'h81; bus.msb_first = 1'b1; bus.repeat_cnt = 4'd1; bus.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) bus.start = 1'b0;
      n_cmp++;
      if ({bus.done, bus.busy, bus.x_valid, bus.x} !== {3'b011, s[7-i]}) begin
        n_err++; $display("FAIL async_reset restart bit%0d: got %b want %b", i, {bus.done, bus.busy, bus.x_valid, bus.x}, {3'b011, s[7-i]});
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.busy, bus.x_valid, bus.x} !== 4'b1000) begin
      n_err++; $display("FAIL async_reset restart done: got %b want 1000", {bus.done, bus.busy, bus.x_valid, bus.x});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [7:0] s;
    s = 8'h3C;
    bus.pattern = 8'h3C; bus.msb_first = 1'b1; bus.repeat_cnt = 4'd1; bus.start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.done, bus.busy, bus.x_valid, bus.x} !== {3'b011, s[7-i]}) begin
        n_err++; $display("FAIL back_to_back a bit%0d: got %b want %b", i, {bus.done, bus.busy, bus.x_valid, bus.x}, {3'b011, s[7-i]});
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.busy, bus.x_valid, bus.x} !== 4'b1000) begin
      n_err++; $display("FAIL back_to_back done: got %b want 1000", {bus.done, bus.busy, bus.x_valid, bus.x});
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.busy, bus.x_valid, bus.x} !== 4'b0000) begin
      n_err++; $display("FAIL back_to_back gap: got %b want 0000", {bus.done, bus.busy, bus.x_valid, bus.x});
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) bus.start = 1'b0;
      n_cmp++;
      if ({bus.done, bus.busy, bus.x_valid, bus.x} !== {3'b011, s[7-i]}) begin
        n_err++; $display("FAIL back_to_back b bit%0d: got %b want %b", i, {bus.done, bus.busy, bus.x_valid, bus.x}, {3'b011, s[7-i]});
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.busy, bus.x_valid, bus.x} !== 4'b1000) begin
      n_err++; $display("FAIL back_to_back done2: got %b want 1000", {bus.done, bus.busy, bus.x_valid, bus.x});
    end
    @(negedge clk);
  endtask

`ifdef SEQ_GEN_PARITY_EN
  task automatic test_parity();
    logic [8:0] s;
    s = 9'b0_0000_1111;
    bus.pattern = 8'b0000_0111; bus.msb_first = 1'b1; bus.repeat_cnt = 4'd2; bus.start = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (i == 0) bus.start = 1'b0;
      n_cmp++;
      if ({bus.done, bus.busy, bus.x_valid, bus.x} !== {3'b011, s[8-(i%9)]}) begin
        n_err++; $display("FAIL parity bit%0d: got %b want %b", i, {bus.done, bus.busy, bus.x_valid, bus.x}, {3'b011, s[8-(i%9)]});
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.busy, bus.x_valid, bus.x} !== 4'b1000) begin
      n_err++; $display("FAIL parity done: got %b want 1000", {bus.done, bus.busy, bus.x_valid, bus.x});
    end
    @(negedge clk);
  endtask
`else
  task automatic test_parity();
    logic [7:0] s;
    s = 8'b0000_0111;
    bus.pattern = 8'b0000_0111; bus.msb_first = 1'b1; bus.repeat_cnt = 4'd2; bus.start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) bus.start = 1'b0;
      n_cmp++;
      if ({bus.done, bus.busy, bus.x_valid, bus.x} !== {3'b011, s[7-(i%8)]}) begin
        n_err++; $display("FAIL no_parity bit%0d: got %b want %b", i, {bus.done, bus.busy, bus.x_valid, bus.x}, {3'b011, s[7-(i%8)]});
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.done, bus.busy, bus.x_valid, bus.x} !== 4'b1000) begin
      n_err++; $display("FAIL no_parity done: got %b want 1000", {bus.done, bus.busy, bus.x_valid, bus.x});
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_repeat();
    test_zero_repeat();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    test_parity();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
